// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, PC select, multiplier FSM states.
package cpu_pkg;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SLL   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_SLT   = 5'd8;
  localparam logic [4:0] ALU_SLTU  = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;
  localparam logic [4:0] ALU_MUL   = 5'd11;
  localparam logic [4:0] ALU_MULH  = 5'd12;
  localparam logic [4:0] ALU_MULHU = 5'd13;
  localparam logic [4:0] ALU_BEQ   = 5'd16;
  localparam logic [4:0] ALU_BNE   = 5'd17;
  localparam logic [4:0] ALU_BLT   = 5'd18;
  localparam logic [4:0] ALU_BGE   = 5'd19;
  localparam logic [4:0] ALU_BLTU  = 5'd20;
  localparam logic [4:0] ALU_BGEU  = 5'd21;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/exe_stage_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle on operand magnitudes,
// sign applied at the end so MULH works on the same unsigned datapath.
//
// state   | meaning
// IDLE    | waiting for start; operands latched on start
// BUSY    | MUL_CYCLES add/shift iterations
// DONE    | product presented for one cycle, then back to IDLE
module mul_iter
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  wr,
  input  logic        we,
  output logic        idle,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  wr_q,
  output logic        we_q
);

  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;

  mul_state_e       state;
  logic [CNT_W-1:0] count;
  logic [63:0]      acc;
  logic [63:0]      mcand;
  logic [31:0]      mplier;
  logic             sign_q;
  logic [4:0]       op_q;

  logic        is_mulh;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] prod;

  // MULH multiplies magnitudes; MUL/MULHU use raw bits (low half of MUL is sign-agnostic)
  assign is_mulh = (op == ALU_MULH);
  assign mag_a   = (is_mulh && a[31]) ? (~a + 32'd1) : a;
  assign mag_b   = (is_mulh && b[31]) ? (~b + 32'd1) : b;

  // multiplier FSM with accumulator, counter and instruction latch
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      sign_q <= 1'b0;
      op_q   <= '0;
      wr_q   <= '0;
      we_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= {32'd0, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            count  <= '0;
            sign_q <= is_mulh & (a[31] ^ b[31]);
            op_q   <= op;
            wr_q   <= wr;
            we_q   <= we;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == CNT_W'(MUL_CYCLES - 1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign prod   = sign_q ? (~acc + 64'd1) : acc;
  assign result = (op_q == ALU_MUL) ? prod[31:0] : prod[63:32];
  assign idle   = (state == ST_IDLE);
  assign busy   = (state == ST_BUSY);
  assign done   = (state == ST_DONE);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: MEM/WB operand forwarding, combinational ALU, branch/jump
// resolution and an iterative multiplier that suspends the front of the pipe.
module exe_stage
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ext_i,
  input  logic [4:0]  rR1_i,
  input  logic [4:0]  rR2_i,
  input  logic [31:0] rD1_i,
  input  logic [31:0] rD2_i,
  input  logic [31:0] current_pc_i,
  input  logic [1:0]  pc_sel_i,
  input  logic        branch_controler_i,
  input  logic        op_A_sel_i,
  input  logic        op_B_sel_i,
  input  logic [4:0]  alu_opcode_i,
  input  logic [4:0]  wr_i,
  input  logic        regfile_we_i,
  input  logic [4:0]  mem_wr_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_data_i,
  input  logic [4:0]  wb_wr_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] alu_result_o,
  output logic [31:0] store_data_o,
  output logic [4:0]  wr_o,
  output logic        regfile_we_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        suspend_o
);

  logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res, mul_result, jalr_sum;
  logic        cmp, taken, redirect_raw, mul_start;
  logic        mul_idle, mul_busy, mul_done, mul_we_q;
  logic [4:0]  mul_wr_q;

  // operand forwarding; MEM is younger so it wins over WB, x0 never forwards
  always_comb begin
    fwd_a = rD1_i;
    fwd_b = rD2_i;
    if (mem_we_i && mem_wr_i != 5'd0 && mem_wr_i == rR1_i)   fwd_a = mem_data_i;
    else if (wb_we_i && wb_wr_i != 5'd0 && wb_wr_i == rR1_i) fwd_a = wb_data_i;
    if (mem_we_i && mem_wr_i != 5'd0 && mem_wr_i == rR2_i)   fwd_b = mem_data_i;
    else if (wb_we_i && wb_wr_i != 5'd0 && wb_wr_i == rR2_i) fwd_b = wb_data_i;
  end

  assign op_a         = op_A_sel_i ? current_pc_i : fwd_a;
  assign op_b         = op_B_sel_i ? ext_i : fwd_b;
  assign store_data_o = fwd_b;

  // single-cycle ALU; mul and branch opcodes produce zero here
  always_comb begin
    alu_res = '0;
    case (alu_opcode_i)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SLL:   alu_res = op_a << op_b[4:0];
      ALU_SRL:   alu_res = op_a >> op_b[4:0];
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_SLT:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {31'd0, op_a < op_b};
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  // branch condition always on the forwarded register operands
  always_comb begin
    cmp = 1'b0;
    case (alu_opcode_i)
      ALU_BEQ:  cmp = (fwd_a == fwd_b);
      ALU_BNE:  cmp = (fwd_a != fwd_b);
      ALU_BLT:  cmp = ($signed(fwd_a) < $signed(fwd_b));
      ALU_BGE:  cmp = ($signed(fwd_a) >= $signed(fwd_b));
      ALU_BLTU: cmp = (fwd_a < fwd_b);
      ALU_BGEU: cmp = (fwd_a >= fwd_b);
      default:  cmp = 1'b0;
    endcase
  end

  assign taken        = branch_controler_i & cmp;
  assign redirect_raw = ((pc_sel_i == PC_BRANCH) && (!branch_controler_i || taken)) ||
                        (pc_sel_i == PC_JALR);
  assign redirect_o   = redirect_raw & mul_idle;
  assign jalr_sum     = fwd_a + ext_i;

  // redirect target select
  always_comb begin
    redirect_pc_o = current_pc_i + 32'd4;
    case (pc_sel_i)
      PC_BRANCH: redirect_pc_o = current_pc_i + ext_i;
      PC_JALR:   redirect_pc_o = {jalr_sum[31:1], 1'b0};
      default:   redirect_pc_o = current_pc_i + 32'd4;
    endcase
  end

  // a flushed bubble carries regfile_we_i=0 and must not start a multiply
  assign mul_start = mul_idle & is_mul_op(alu_opcode_i) & regfile_we_i;
  assign suspend_o = mul_start | mul_busy;

  mul_iter #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (mul_start),
    .op     (alu_opcode_i),
    .a      (fwd_a),
    .b      (fwd_b),
    .wr     (wr_i),
    .we     (regfile_we_i),
    .idle   (mul_idle),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_result),
    .wr_q   (mul_wr_q),
    .we_q   (mul_we_q)
  );

  assign alu_result_o = mul_done ? mul_result : alu_res;

  // writeback target: latched during DONE because ID/EXE zeroes it while suspended
  always_comb begin
    wr_o         = wr_i;
    regfile_we_o = regfile_we_i;
    if (mul_done) begin
      wr_o         = mul_wr_q;
      regfile_we_o = mul_we_q;
    end else if (mul_busy || mul_start) begin
      wr_o         = '0;
      regfile_we_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] ext, rd1, rd2, pc, mem_data, wb_data;
  logic [4:0]  rr1, rr2, opc, wr, mem_wr, wb_wr;
  logic [1:0]  pc_sel;
  logic        br, a_sel, b_sel, we, mem_we, wb_we;
  logic [31:0] alu_result, store_data, redirect_pc;
  logic [4:0]  wr_out;
  logic        we_out, redirect, suspend;

  int passed = 0, failed = 0, total = 0;

  exe_stage dut (
    .clk_i(clk), .rst_i(rst), .ext_i(ext), .rR1_i(rr1), .rR2_i(rr2),
    .rD1_i(rd1), .rD2_i(rd2), .current_pc_i(pc), .pc_sel_i(pc_sel),
    .branch_controler_i(br), .op_A_sel_i(a_sel), .op_B_sel_i(b_sel),
    .alu_opcode_i(opc), .wr_i(wr), .regfile_we_i(we),
    .mem_wr_i(mem_wr), .mem_we_i(mem_we), .mem_data_i(mem_data),
    .wb_wr_i(wb_wr), .wb_we_i(wb_we), .wb_data_i(wb_data),
    .alu_result_o(alu_result), .store_data_o(store_data), .wr_o(wr_out),
    .regfile_we_o(we_out), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
    .suspend_o(suspend)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ext = 0; rd1 = 0; rd2 = 0; pc = 0; mem_data = 0; wb_data = 0;
    rr1 = 0; rr2 = 0; opc = ALU_ADD; wr = 0; mem_wr = 0; wb_wr = 0;
    pc_sel = PC_PLUS4; br = 0; a_sel = 0; b_sel = 0; we = 0; mem_we = 0; wb_we = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] rf);
    if (mem_we && mem_wr != 0 && mem_wr == r) return mem_data;
    if (wb_we && wb_wr != 0 && wb_wr == r) return wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] m_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    longint sa, sb;
    s = b % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a * (32'd1 << s);
      ALU_SRL:   return a / (32'd1 << s);
      ALU_SRA:   return 32'(sa / (64'sd1 <<< s) - ((sa < 0 && (sa % (64'sd1 <<< s)) != 0) ? 1 : 0));
      ALU_SLT:   return (sa < sb) ? 1 : 0;
      ALU_SLTU:  return ({32'd0, a} < {32'd0, b}) ? 1 : 0;
      ALU_PASSB: return b;
      default:   return 0;
    endcase
  endfunction

  function automatic logic m_cmp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    case (op)
      ALU_BEQ:  return ua == ub;
      ALU_BNE:  return ua != ub;
      ALU_BLT:  return sa < sb;
      ALU_BGE:  return sa >= sb;
      ALU_BLTU: return ua < ub;
      ALU_BGEU: return ua >= ub;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_mul(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] up;
    logic signed [63:0] sp;
    up = {32'd0, a} * {32'd0, b};
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    if (op == ALU_MUL) return up[31:0];
    if (op == ALU_MULHU) return up[63:32];
    return sp[63:32];
  endfunction

  // one multiply: hold operands, zero wr/we after launch as ID/EXE does, count suspend cycles
  task automatic run_mul(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] dst);
    int sus;
    next_cycle();
    clear_inputs();
    opc = op; rd1 = a; rd2 = b; rr1 = 5'd3; rr2 = 5'd4; wr = dst; we = 1;
    sus = 0;
    @(negedge clk);
    while (suspend === 1'b1 && sus < 100) begin
      sus++;
      next_cycle();
      wr = 0; we = 0; pc_sel = PC_BRANCH;
      @(negedge clk);
      if (sus == 5) check({tag, " busy_redirect"}, redirect, 0);
      if (sus == 5) check({tag, " busy_we"}, we_out, 0);
    end
    check({tag, " suspend_cycles"}, sus, 1 + 32);
    check({tag, " result"}, alu_result, m_mul(op, a, b));
    check({tag, " wr"}, wr_out, dst);
    check({tag, " we"}, we_out, 1);
    check({tag, " done_redirect"}, redirect, 0);
  endtask

  localparam int NOPS = 17;
  logic [4:0] op_list [NOPS] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
                                  ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB, ALU_BEQ, ALU_BNE,
                                  ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
  logic [4:0] mul_list [3] = '{ALU_MUL, ALU_MULH, ALU_MULHU};

  initial begin
    logic [31:0] fa, fb, ea, eb, exp_res, exp_pc;
    logic exp_redir;

    // reset state
    rst = 1;
    clear_inputs();
    #1;
    check("reset_alu", alu_result, 0);
    check("reset_suspend", suspend, 0);
    check("reset_we", we_out, 0);
    check("reset_redirect", redirect, 0);
    #20;
    @(negedge clk) rst = 0;

    // forwarding priority
    next_cycle();
    rr1 = 5; mem_we = 1; mem_wr = 5; mem_data = 32'h10; wb_we = 1; wb_wr = 5; wb_data = 32'h20;
    b_sel = 1; ext = 1; opc = ALU_ADD;
    @(negedge clk) check("fwd_mem", alu_result, 32'h11);
    next_cycle();
    mem_wr = 0;
    @(negedge clk) check("fwd_wb", alu_result, 32'h21);

    // ALU edge cases
    next_cycle(); clear_inputs();
    opc = ALU_SUB; rd1 = 0; rd2 = 1;
    @(negedge clk) check("sub_wrap", alu_result, 32'hFFFF_FFFF);
    next_cycle();
    opc = ALU_SRA; rd1 = 32'h8000_0000; rd2 = 4;
    @(negedge clk) check("sra", alu_result, 32'hF800_0000);
    next_cycle();
    opc = ALU_SLT; rd1 = 32'hFFFF_FFFF; rd2 = 1;
    @(negedge clk) check("slt", alu_result, 1);
    next_cycle();
    opc = ALU_SLTU;
    @(negedge clk) check("sltu", alu_result, 0);

    // branch / jalr
    next_cycle(); clear_inputs();
    opc = ALU_BEQ; br = 1; pc_sel = PC_BRANCH; pc = 32'h100; ext = 32'h20; rd1 = 7; rd2 = 7;
    @(negedge clk);
    check("beq_taken", redirect, 1);
    check("beq_target", redirect_pc, 32'h120);
    check("beq_alu_zero", alu_result, 0);
    next_cycle();
    rd2 = 8;
    @(negedge clk) check("beq_not_taken", redirect, 0);
    next_cycle(); clear_inputs();
    pc_sel = PC_JALR; rd1 = 32'h203; ext = 0;
    @(negedge clk);
    check("jalr_redirect", redirect, 1);
    check("jalr_target", redirect_pc, 32'h202);

    // multiplies
    run_mul("mulh", ALU_MULH, 32'hFFFF_FFFD, 32'd5, 5'd9);
    run_mul("mul", ALU_MUL, 32'hFFFF_FFFD, 32'd5, 5'd9);
    run_mul("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
    check("mulhu_value", alu_result, 32'hFFFF_FFFE);
    // back-to-back ADD right after DONE
    next_cycle(); clear_inputs();
    opc = ALU_ADD; rd1 = 3; b_sel = 1; ext = 4; wr = 2; we = 1;
    @(negedge clk);
    check("b2b_suspend", suspend, 0);
    check("b2b_result", alu_result, 7);
    check("b2b_we", we_out, 1);
    check("b2b_wr", wr_out, 2);

    // bubble mul never starts
    next_cycle(); clear_inputs();
    opc = ALU_MUL; rd1 = 3; rd2 = 3; we = 0;
    @(negedge clk) check("bubble_no_suspend", suspend, 0);

    // async reset mid-multiply
    next_cycle(); clear_inputs();
    opc = ALU_MUL; rd1 = 32'h1234; rd2 = 32'h55; wr = 7; we = 1;
    next_cycle(); wr = 0; we = 0;
    repeat (9) @(posedge clk);
    #2 check("pre_reset_suspend", suspend, 1);
    rst = 1;
    #1 check("reset_async_suspend", suspend, 0);
    clear_inputs();
    #1;
    check("reset_mid_alu", alu_result, 0);
    check("reset_mid_we", we_out, 0);
    @(negedge clk) rst = 0;
    @(negedge clk);
    check("post_reset_suspend", suspend, 0);
    check("post_reset_alu", alu_result, 0);
    check("post_reset_we", we_out, 0);

    // randomized single-cycle ops vs model
    for (int i = 0; i < 200; i++) begin
      next_cycle();
      opc = op_list[$urandom_range(0, NOPS - 1)];
      br = (opc >= ALU_BEQ);
      pc_sel = 2'($urandom_range(0, 2));
      rr1 = 5'($urandom_range(0, 7)); rr2 = 5'($urandom_range(0, 7));
      rd1 = $urandom; rd2 = ($urandom_range(0, 3) == 0) ? rd1 : $urandom;
      mem_wr = 5'($urandom_range(0, 7)); wb_wr = 5'($urandom_range(0, 7));
      mem_we = 1'($urandom); wb_we = 1'($urandom);
      mem_data = $urandom; wb_data = $urandom;
      a_sel = 1'($urandom); b_sel = 1'($urandom);
      ext = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      pc = $urandom; wr = 5'($urandom); we = 1'($urandom);
      fa = m_fwd(rr1, rd1); fb = m_fwd(rr2, rd2);
      ea = a_sel ? pc : fa; eb = b_sel ? ext : fb;
      exp_res = m_alu(opc, ea, eb);
      exp_redir = (pc_sel == 1 && (!br || m_cmp(opc, fa, fb))) || pc_sel == 2;
      exp_pc = (pc_sel == 1) ? pc + ext : ((fa + ext) & ~32'd1);
      @(negedge clk);
      check($sformatf("rnd%0d_alu_op%0d", i, opc), alu_result, exp_res);
      check($sformatf("rnd%0d_store", i), store_data, fb);
      check($sformatf("rnd%0d_redirect", i), redirect, exp_redir);
      if (pc_sel != 0) check($sformatf("rnd%0d_target", i), redirect_pc, exp_pc);
      check($sformatf("rnd%0d_wr", i), {we_out, wr_out}, {we, wr});
    end

    // randomized multiplies
    for (int i = 0; i < 6; i++) begin
      run_mul($sformatf("rmul%0d", i), mul_list[$urandom_range(0, 2)], $urandom, $urandom,
              5'($urandom_range(1, 31)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
